// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
//   Shared types and helpers for the round-robin grant scheduler.
//   - arb_state_t : scheduler FSM state (no owner / owner holds grant)
//   - rotl1       : rotate a one-hot ring one place toward the higher index,
//                   with bit n-1 wrapping to bit 0
//   - onehot2idx  : binary index of the set bit in a one-hot vector
//   The helpers work on ARB_MAX_N-bit vectors. Callers zero-extend their
//   N-bit operands and truncate the result back to N bits.
// ---------------------------------------------------------------------------
package rr_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int ARB_MAX_N = 64;
    localparam int ARB_IDX_W = 6;

    // Bit i moves to bit (i+1) mod n. Bits at or above n stay zero.
    function automatic logic [ARB_MAX_N-1:0] rotl1(input logic [ARB_MAX_N-1:0] v,
                                                   input int n);
        logic [ARB_MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (i < n) r[(i + 1) % n] = v[i];
        end
        return r;
    endfunction

    // Returns 0 for an all-zero vector.
    function automatic logic [ARB_IDX_W-1:0] onehot2idx(input logic [ARB_MAX_N-1:0] v);
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (v[i]) idx = idx | ARB_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational circular priority pick. Returns the first set request bit
//   at or after the one-hot start position, searching toward the higher
//   index and wrapping around.
//   Ports:
//     i_req   [N]  request vector
//     i_start [N]  one-hot start position (highest priority)
//     o_win   [N]  one-hot winner (all-zero if no request)
//     o_any   1    at least one request set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_start,
    output logic [N-1:0] o_win,
    output logic         o_any
);

    localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_mask;
    logic [2*N-1:0] w_masked;
    logic [2*N-1:0] w_low;

    // Search a doubled copy of the request vector. Bits below the start
    // position in the lower copy are masked off. The lowest surviving bit is
    // the circular-first winner. The upper copy supplies the wrapped part.
    assign w_dbl    = {i_req, i_req};
    assign w_mask   = ~({{N{1'b0}}, i_start} - ONE);
    assign w_masked = w_dbl & w_mask;
    assign w_low    = w_masked & (~w_masked + ONE);

    assign o_win = w_low[N-1:0] | w_low[2*N-1:N];
    assign o_any = |i_req;

endmodule

// File: rtl/rr_grant_scheduler.sv
// ---------------------------------------------------------------------------
// rr_grant_scheduler
//   Round-robin scheduler sharing one resource among N requesters. The owner
//   keeps its registered one-hot grant while its request stays high. When the
//   owner releases, the pointer moves one place past the owner. In the same
//   edge the next requester, searched from that position, gets the grant, so
//   there is no idle cycle between owners.
//   Optional feature macro: ARB_QUANTUM_EN. When it is defined, an owner is
//   forced out after QUANTUM consecutive cycles if another requester is
//   waiting.
//   Ports:
//     clk          clock, rising edge
//     rst          synchronous active-high reset
//     req   [N]    request vector
//     grant [N]    registered one-hot grant (zero when idle)
//     grant_valid  registered |grant
//     grant_idx    registered binary index of the owner (0 when idle)
//     ptr   [N]    one-hot priority pointer
// ---------------------------------------------------------------------------
module rr_grant_scheduler
    import rr_arb_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int QUANTUM = 8,
    localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx,
    output logic [N-1:0]  ptr
);

    arb_state_t    r_state, w_state_nxt;
    logic [N-1:0]  r_grant, w_grant_nxt;
    logic [N-1:0]  r_ptr,   w_ptr_nxt;
    logic          r_valid;
    logic [IW-1:0] r_idx;

    logic [N-1:0]  w_ptr_adv;
    logic [N-1:0]  w_start;
    logic [N-1:0]  w_win;
    logic          w_any;
    logic          w_owner_req;
    logic          w_release;

    // Position just past the current owner. It is the new pointer on release
    // and the search start for the handover winner.
    assign w_ptr_adv   = N'(rotl1(ARB_MAX_N'(r_grant), N));
    assign w_start     = (r_state == ARB_GRANT) ? w_ptr_adv : r_ptr;
    assign w_owner_req = |(req & r_grant);

    rr_pick #(.N(N)) u_pick (
        .i_req   (req),
        .i_start (w_start),
        .o_win   (w_win),
        .o_any   (w_any)
    );

`ifdef ARB_QUANTUM_EN
    localparam int CW = $clog2(QUANTUM + 1);

    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic          w_others;
    logic          w_expired;

    assign w_others  = |(req & ~r_grant);
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_expired = (w_cnt_inc == CW'(QUANTUM));
    // Forced release looks exactly like a voluntary one. The owner sits last
    // in the search order from w_ptr_adv, so another waiter always wins.
    assign w_release = !w_owner_req || (w_expired && w_others);
`else
    assign w_release = !w_owner_req;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
`ifdef ARB_QUANTUM_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_win;
                    w_state_nxt = ARB_GRANT;
`ifdef ARB_QUANTUM_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            ARB_GRANT: begin
                if (w_release) begin
                    w_ptr_nxt = w_ptr_adv;
`ifdef ARB_QUANTUM_EN
                    w_cnt_nxt = '0;
`endif
                    if (w_any) begin
                        w_grant_nxt = w_win;
                    end else begin
                        w_grant_nxt = '0;
                        w_state_nxt = ARB_IDLE;
                    end
                end else begin
`ifdef ARB_QUANTUM_EN
                    // A sole requester at the limit starts a fresh quantum.
                    w_cnt_nxt = w_expired ? '0 : w_cnt_inc;
`endif
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_ptr   <= N'(1);
`ifdef ARB_QUANTUM_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_valid <= |w_grant_nxt;
            r_idx   <= IW'(onehot2idx(ARB_MAX_N'(w_grant_nxt)));
            r_ptr   <= w_ptr_nxt;
`ifdef ARB_QUANTUM_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_idx   = r_idx;
    assign ptr         = r_ptr;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
module tb_rr_grant_scheduler;
    localparam int N = 4;
    localparam int Q = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = 4'b1111;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_idx;
    logic [N-1:0] ptr;

    int n_tests = 0;
    int n_fail  = 0;

    rr_grant_scheduler #(.N(N), .QUANTUM(Q)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .ptr         (ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // The model tracks the owner as an integer (-1 = nobody), the priority
    // position as an integer, and the number of cycles the owner has held
    // the grant.
    bit m_known = 0;
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    function automatic int first_from(input logic [N-1:0] r, input int s, input int excl);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (s + k) % N;
            if (j != excl && r[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_known = 1; m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_known) begin
            if (m_owner < 0) begin
                if (req != 0) begin
                    m_owner = first_from(req, m_ptr, -1);
                    m_cnt = 0;
                end
            end else begin
                bit others, force_rel;
                others = (req & ~(4'b0001 << m_owner)) != 0;
                force_rel = 0;
`ifdef ARB_QUANTUM_EN
                force_rel = (m_cnt + 1 == Q) && others;
`endif
                if (!req[m_owner] || force_rel) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = first_from(req, m_ptr, m_owner);
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == Q) m_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("model_grant", 32'(grant), (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
            chk("model_valid", 32'(grant_valid), (m_owner < 0) ? 32'd0 : 32'd1);
            chk("model_idx",   32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
            chk("model_ptr",   32'(ptr), 32'(1 << m_ptr));
        end
    end

    task automatic tick(input logic [N-1:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] rr;
        // 1: reset holds everything cleared even with all requests high
        tick(4'b1111, 1'b1);
        tick(4'b1111, 1'b1);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(grant_valid), 32'h0);
        chk("rst_idx",   32'(grant_idx), 32'h0);
        chk("rst_ptr",   32'(ptr), 32'h1);
        // 2: first grant one cycle after request, then hold
        tick(4'b0110, 1'b0);
        chk("t2_grant", 32'(grant), 32'h2);
        chk("t2_idx",   32'(grant_idx), 32'h1);
        tick(4'b0110, 1'b0);
        chk("t2_hold",  32'(grant), 32'h2);
        chk("t2_ptr",   32'(ptr), 32'h1);
        // 3: handover without bubble, then release to idle
        tick(4'b0100, 1'b0);
        chk("t3_grant", 32'(grant), 32'h4);
        chk("t3_ptr",   32'(ptr), 32'h4);
        tick(4'b0000, 1'b0);
        chk("t3_idle",  32'(grant), 32'h0);
        chk("t3_valid", 32'(grant_valid), 32'h0);
        chk("t3_ptr2",  32'(ptr), 32'h8);
        // 4: wrap-around search from the MSB
        tick(4'b0011, 1'b0);
        chk("t4_grant", 32'(grant), 32'h1);
        chk("t4_idx",   32'(grant_idx), 32'h0);
        tick(4'b0010, 1'b0);
        chk("t4_ptr",   32'(ptr), 32'h2);
        chk("t4_hand",  32'(grant), 32'h2);
        tick(4'b0000, 1'b0);
        // 5: all requesting from reset
        tick(4'b1111, 1'b1);
        for (int t = 0; t < 14; t++) begin
            tick(4'b1111, 1'b0);
`ifdef ARB_QUANTUM_EN
            chk("t5_quantum", 32'(grant), 32'(1 << ((t / 3) % 4)));
`else
            chk("t5_hold", 32'(grant), 32'h1);
`endif
        end
        // 6: reset mid-grant, then restart
        tick(4'b0000, 1'b1);
        tick(4'b0100, 1'b0);
        chk("t6_pre",  32'(grant), 32'h4);
        tick(4'b0100, 1'b1);
        chk("t6_rst",  32'(grant), 32'h0);
        chk("t6_ptr",  32'(ptr), 32'h1);
        tick(4'b0100, 1'b0);
        chk("t6_regr", 32'(grant), 32'h4);
        // non-owner changes do not disturb; owner drop hands over past it
        tick(4'b0101, 1'b0);
        chk("nonowner", 32'(grant), 32'h4);
        tick(4'b1011, 1'b0);
        chk("drop_hand", 32'(grant), 32'h8);
        chk("drop_ptr",  32'(ptr), 32'h8);
        tick(4'b0000, 1'b0);
        // sticky pseudo-random traffic against the model
        rr = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) rr = rr ^ (4'b0001 << $urandom_range(0, 3));
            tick(rr, ($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
